// File: rtl/lsu_serial_port_pkg.sv
// lsu_serial_port_pkg: shared size/state encodings and constants for the serial load/store unit.
package lsu_serial_port_pkg;
    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;
    localparam logic [31:0] ZeroWord = 32'h0;
    localparam logic [7:0] ZeroByte = 8'h0;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == MEM_BYTE ? 3'd1 : size == MEM_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/lsu_serial_port_if.sv
// lsu_serial_port_if: pipeline request/response and narrow memory bus signals of the load/store unit.
interface lsu_serial_port_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_sign_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [XLEN-1:0]   req_wdata_i;
    logic              flush_i;
    logic              resp_valid_o;
    logic [XLEN-1:0]   resp_rdata_o;
    logic              busy_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [BUS_W/8-1:0] mem_be_o;
    logic [BUS_W-1:0]  mem_wdata_o;
    logic [BUS_W-1:0]  mem_rdata_i;
    logic              mem_stall_i;
    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_sign_i, req_addr_i, req_wdata_i, flush_i,
               mem_rdata_i, mem_stall_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, busy_o,
               mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
    modport master (
        output req_valid_i, req_we_i, req_size_i, req_sign_i, req_addr_i, req_wdata_i, flush_i,
               mem_rdata_i, mem_stall_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, busy_o,
               mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_serial_port_rd_track.sv
// lsu_rd_track: RD_LAT-deep valid+beat-tag pipe matching read beats to returning bus data.
module lsu_rd_track #(
    parameter int RD_LAT = 2,
    parameter int TAG_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_head_valid,
    output logic [TAG_W-1:0] o_head_tag
);
    logic [RD_LAT-1:0]            r_valid;
    logic [RD_LAT-1:0][TAG_W-1:0] r_tag;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
            r_tag <= '0;
        end else begin
            r_valid[0] <= i_push;
            r_tag[0] <= i_tag;
            for (int s = 1; s < RD_LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign o_head_valid = r_valid[RD_LAT-1];
    assign o_head_tag = r_tag[RD_LAT-1];
endmodule

// File: rtl/lsu_serial_port.sv
// lsu_serial_port: splits one load/store into BUS_W-wide beats on a byte-addressed bus and
// reassembles and extends load data returning after a fixed read latency.
module lsu_serial_port
    import lsu_serial_port_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 8,
    parameter int RD_LAT = 2
) (
    input logic clk,
    input logic rst,
    lsu_serial_port_if.slave lsu
);
    localparam int BB = BUS_W / 8;

    state_t            r_state, w_next;
    logic [1:0]        r_beat, r_nlast;
    logic [2:0]        r_nbytes;
    logic              r_sign, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata, r_asm, w_ext;
    logic              w_accept, w_xfer, w_beat_go, w_last, w_head_valid;
    logic [1:0]        w_head_tag;
    logic [2:0]        w_req_nbytes;
    logic [7:0]        w_off;

    lsu_rd_track #(.RD_LAT(RD_LAT), .TAG_W(2)) u_track (
        .clk(clk),
        .rst(rst),
        .i_flush(lsu.flush_i),
        .i_push(w_beat_go && r_state == S_RD),
        .i_tag(r_beat),
        .o_head_valid(w_head_valid),
        .o_head_tag(w_head_tag)
    );

    always_comb begin
        lsu.resp_valid_o = r_state == S_DONE;
        lsu.req_ready_o = r_state == S_IDLE && !lsu.resp_valid_o;
        lsu.busy_o = (lsu.req_valid_i && !lsu.resp_valid_o) || (r_state != S_IDLE && r_state != S_DONE);
        w_accept = lsu.req_valid_i && lsu.req_ready_o;
        w_req_nbytes = size_bytes(lsu.req_size_i);
        w_xfer = r_state == S_WR || r_state == S_RD;
        w_beat_go = w_xfer && !lsu.mem_stall_i;
        w_last = r_beat == r_nlast;
        w_off = 8'(w_head_tag) * 8'(BUS_W);
        // in-order beats: the last tag reaching the head means every beat has returned
        w_next = r_state == S_IDLE  ? (w_accept ? (lsu.req_we_i ? S_WR : S_RD) : S_IDLE)
               : r_state == S_WR    ? (w_beat_go && w_last ? S_DONE : S_WR)
               : r_state == S_RD    ? (w_beat_go && w_last ? S_DRAIN : S_RD)
               : r_state == S_DRAIN ? (w_head_valid && w_head_tag == r_nlast ? S_DONE : S_DRAIN)
               : S_IDLE;
        lsu.mem_addr_o = w_xfer ? r_addr + ADDR_W'(r_beat) * ADDR_W'(BB) : '0;
        lsu.mem_we_o = w_beat_go && r_state == S_WR;
        lsu.mem_wdata_o = r_state == S_WR ? BUS_W'(r_wdata >> (8'(r_beat) * 8'(BUS_W))) : '0;
        lsu.mem_be_o = '0;
        for (int j = 0; j < BB; j++)
            lsu.mem_be_o[j] = w_beat_go && (4'(r_beat) * 4'(BB) + 4'(j) < {1'b0, r_nbytes});
        w_ext = r_nbytes == 3'd1 ? {{(XLEN-8){r_sign & r_asm[7]}}, r_asm[7:0]}
              : r_nbytes == 3'd2 ? {{(XLEN-16){r_sign & r_asm[15]}}, r_asm[15:0]}
              : r_asm;
        lsu.resp_rdata_o = r_state == S_DONE && !r_we ? w_ext : XLEN'(ZeroWord);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat <= '0;
            r_nlast <= '0;
            r_nbytes <= '0;
            r_sign <= 1'b0;
            r_we <= 1'b0;
            r_addr <= '0;
            r_wdata <= '0;
            r_asm <= '0;
        end else if (lsu.flush_i && r_state != S_IDLE) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_beat <= '0;
                r_nlast <= 2'((w_req_nbytes - 3'd1) / 3'(BB));
                r_nbytes <= w_req_nbytes;
                r_sign <= lsu.req_sign_i;
                r_we <= lsu.req_we_i;
                r_addr <= lsu.req_addr_i;
                r_wdata <= lsu.req_wdata_i;
                r_asm <= '0;
            end
            if (w_beat_go)
                r_beat <= r_beat + 2'd1;
            if (w_head_valid)
                r_asm[w_off +: BUS_W] <= lsu.mem_rdata_i;
        end
    end
endmodule
